// File: rtl/fft8_pkg.sv
// Shared sizing and bank-select constants for the fft8 front end.
package fft8_pkg;

  localparam int DATA_W = 16;
  localparam int N_PTS  = 8;
  localparam int IDX_W  = $clog2(N_PTS);
  localparam int CNT_W  = 16;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  function automatic logic other_bank(input logic bank);
    return (bank == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/fft8_pingpong_ctrl.sv
// Ping-pong bookkeeping: bank full flags, write/read pointers, output load strobe.
// One-cycle load after a frame completes; ready drops only when both banks hold frames.
module fft8_pingpong_ctrl
  import fft8_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic             s_sof,
  input  logic             frame_ready,
  output logic             s_ready,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [IDX_W-1:0] wr_idx,
  output logic             load,
  output logic             load_bank,
  output logic             load_byp,
  output logic             frame_valid,
  output logic             handoff,
  output logic             sync_err
);

  logic [1:0]       full_q, full_n;
  logic             wr_bank_q, wr_bank_n;
  logic             rd_bank_q, rd_bank_n;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_n;
  logic             rdy_q, vld_q, err_q;

  logic accept, resync, complete, handoff_c;
  logic load_c, load_bank_c, byp_c;

  always_comb begin
    accept    = s_valid & rdy_q;
    resync    = accept & s_sof & (wr_idx_q != '0);
    complete  = accept & ~resync & (wr_idx_q == LAST_IDX);
    handoff_c = vld_q & frame_ready;

    wr_idx_n  = wr_idx_q;
    wr_bank_n = wr_bank_q;
    if (accept) begin
      if (resync)        wr_idx_n = IDX_W'(1);
      else if (complete) wr_idx_n = '0;
      else               wr_idx_n = wr_idx_q + 1'b1;
    end
    if (complete) wr_bank_n = other_bank(wr_bank_q);

    // The displayed bank is full and never written, so the set and clear target different banks.
    full_n = full_q;
    if (handoff_c) full_n[rd_bank_q] = 1'b0;
    if (complete)  full_n[wr_bank_q] = 1'b1;

    rd_bank_n = handoff_c ? other_bank(rd_bank_q) : rd_bank_q;

    load_c      = 1'b0;
    load_bank_c = rd_bank_q;
    byp_c       = 1'b0;
    if (handoff_c) begin
      // A frame completing on this very edge is forwarded so valid never bubbles.
      load_bank_c = other_bank(rd_bank_q);
      byp_c       = complete;
      load_c      = full_q[load_bank_c] | complete;
    end else if (!vld_q) begin
      load_c = full_q[rd_bank_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= BANK0;
      rd_bank_q <= BANK0;
      wr_idx_q  <= '0;
      rdy_q     <= 1'b0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_n;
      wr_bank_q <= wr_bank_n;
      rd_bank_q <= rd_bank_n;
      wr_idx_q  <= wr_idx_n;
      rdy_q     <= ~&full_n;
      vld_q     <= load_c | (vld_q & ~handoff_c);
      err_q     <= resync;
    end
  end

  assign s_ready     = rdy_q;
  assign wr_en       = accept;
  assign wr_bank     = wr_bank_q;
  assign wr_idx      = resync ? '0 : wr_idx_q;
  assign load        = load_c;
  assign load_bank   = load_bank_c;
  assign load_byp    = byp_c;
  assign frame_valid = vld_q;
  assign handoff     = handoff_c;
  assign sync_err    = err_q;

endmodule

// File: rtl/fft8_sample_collector.sv
// Packs a 16-bit sample stream into 8-point frames, ping-pong buffered, presented in parallel.
// Frame valid one cycle after its 8th accept; s_ready falls only when both banks are held.
module fft8_sample_collector
  import fft8_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  input  logic              s_sof_i,
  output logic              s_ready_o,
  output logic [DATA_W-1:0] x0_o,
  output logic [DATA_W-1:0] x1_o,
  output logic [DATA_W-1:0] x2_o,
  output logic [DATA_W-1:0] x3_o,
  output logic [DATA_W-1:0] x4_o,
  output logic [DATA_W-1:0] x5_o,
  output logic [DATA_W-1:0] x6_o,
  output logic [DATA_W-1:0] x7_o,
  output logic              frame_valid_o,
  input  logic              frame_ready_i,
  output logic              sync_err_o,
  output logic [CNT_W-1:0]  frame_cnt_o
);

  logic [DATA_W-1:0] bank_mem [2][N_PTS];
  logic [DATA_W-1:0] x_q [N_PTS];
  logic [CNT_W-1:0]  cnt_q;

  logic             wr_en, wr_bank, load, load_bank, load_byp, handoff;
  logic [IDX_W-1:0] wr_idx;

  fft8_pingpong_ctrl u_ctrl (
    .clk         (clk_i),
    .rst         (rst_i),
    .s_valid     (s_valid_i),
    .s_sof       (s_sof_i),
    .frame_ready (frame_ready_i),
    .s_ready     (s_ready_o),
    .wr_en       (wr_en),
    .wr_bank     (wr_bank),
    .wr_idx      (wr_idx),
    .load        (load),
    .load_bank   (load_bank),
    .load_byp    (load_byp),
    .frame_valid (frame_valid_o),
    .handoff     (handoff),
    .sync_err    (sync_err_o)
  );

  // Storage needs no reset: a bank is only read after all eight slots were rewritten.
  always_ff @(posedge clk_i) begin
    if (wr_en) bank_mem[wr_bank][wr_idx] <= s_data_i;
  end

  for (genvar i = 0; i < N_PTS; i++) begin : g_out
    localparam bit IS_LAST = (i == N_PTS - 1);
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        x_q[i] <= '0;
      end else if (load) begin
        if (IS_LAST && load_byp) x_q[i] <= s_data_i;
        else                     x_q[i] <= bank_mem[load_bank][i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        cnt_q <= '0;
    else if (handoff) cnt_q <= cnt_q + 1'b1;
  end

  assign x0_o        = x_q[0];
  assign x1_o        = x_q[1];
  assign x2_o        = x_q[2];
  assign x3_o        = x_q[3];
  assign x4_o        = x_q[4];
  assign x5_o        = x_q[5];
  assign x6_o        = x_q[6];
  assign x7_o        = x_q[7];
  assign frame_cnt_o = cnt_q;

endmodule

// File: tb/tb_fft8_sample_collector.sv
// Bench for fft8_sample_collector: directed table, corner sequences, random run against a frame scoreboard.
module tb_fft8_sample_collector;
  import fft8_pkg::*;

  typedef logic [N_PTS-1:0][DATA_W-1:0] frame_t;
  typedef struct {
    frame_t           samp;
    logic             sof;
    frame_t           expf;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0, s_sof = 1'b0, fr = 1'b0;
  logic              s_ready, fv, sync_err;
  logic [DATA_W-1:0] xo [N_PTS];
  logic [CNT_W-1:0]  frame_cnt;

  fft8_sample_collector dut (
    .clk_i(clk), .rst_i(rst), .s_data_i(s_data), .s_valid_i(s_valid), .s_sof_i(s_sof),
    .s_ready_o(s_ready),
    .x0_o(xo[0]), .x1_o(xo[1]), .x2_o(xo[2]), .x3_o(xo[3]),
    .x4_o(xo[4]), .x5_o(xo[5]), .x6_o(xo[6]), .x7_o(xo[7]),
    .frame_valid_o(fv), .frame_ready_i(fr), .sync_err_o(sync_err), .frame_cnt_o(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic frame_t xpack();
    frame_t f;
    for (int k = 0; k < N_PTS; k++) f[k] = xo[k];
    return f;
  endfunction

  // Scoreboard: frames assembled from observed accepts, compared at each hand-off.
  frame_t           exp_q[$];
  frame_t           part, px, ef;
  int               pidx = 0;
  int               hand_total = 0;
  logic [CNT_W-1:0] cnt_m = '0;
  logic             err_m = 1'b0, pv = 1'b0, phs = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      pidx = 0; cnt_m = '0; err_m = 1'b0; pv = 1'b0; phs = 1'b0;
    end else begin
      chk("sync_err", 128'(sync_err), 128'(err_m));
      err_m = 1'b0;
      if (pv && !phs) begin
        chk("valid_hold", 128'(fv), 128'(1));
        chk("data_hold", 128'(xpack()), 128'(px));
      end
      if (fv && fr) begin
        hand_total++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow actual=frame_presented required=no_frame");
        end else begin
          ef = exp_q.pop_front();
          chk("sb_frame", 128'(xpack()), 128'(ef));
        end
        chk("sb_cnt", 128'(frame_cnt), 128'(cnt_m));
        cnt_m++;
      end
      if (s_valid && s_ready) begin
        if (s_sof && pidx != 0) begin pidx = 0; err_m = 1'b1; end
        part[pidx] = s_data;
        pidx++;
        if (pidx == N_PTS) begin exp_q.push_back(part); pidx = 0; end
      end
      pv = fv; phs = fv && fr; px = xpack();
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input logic sof);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof;
    while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=ready_low required=ready_high");
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  vec_t   vec [3];
  frame_t e;
  int     target, cyc;

  initial begin
    vec[0] = '{samp: {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, sof: 1'b1,
               expf: {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, exp_cnt: 16'd1};
    vec[1] = '{samp: {16'hAAAA, 16'h5555, 16'hFFFE, 16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000}, sof: 1'b0,
               expf: {16'hAAAA, 16'h5555, 16'hFFFE, 16'h0001, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000}, exp_cnt: 16'd2};
    vec[2] = '{samp: {16'h8001, 16'h7FFE, 16'hFF00, 16'h00FF, 16'hF0F0, 16'h0F0F, 16'hABCD, 16'h1234}, sof: 1'b1,
               expf: {16'h8001, 16'h7FFE, 16'hFF00, 16'h00FF, 16'hF0F0, 16'h0F0F, 16'hABCD, 16'h1234}, exp_cnt: 16'd3};

    // Reset state
    repeat (2) begin @(posedge clk); #1; end
    chk("rst_ready", 128'(s_ready), 128'(0));
    chk("rst_valid", 128'(fv), 128'(0));
    chk("rst_cnt", 128'(frame_cnt), 128'(0));
    chk("rst_x", 128'(xpack()), 128'(0));
    chk("rst_err", 128'(sync_err), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 128'(s_ready), 128'(1));

    // Directed frames with latency and count
    for (int k = 0; k < 3; k++) begin
      fr = 1'b1;
      for (int j = 0; j < N_PTS; j++) send(vec[k].samp[j], (j == 0) && vec[k].sof);
      chk("tbl_latency_early", 128'(fv), 128'(0));
      @(posedge clk); #1;
      chk("tbl_latency_valid", 128'(fv), 128'(1));
      chk("tbl_frame", 128'(xpack()), 128'(vec[k].expf));
      @(posedge clk); #1;
      chk("tbl_cnt", 128'(frame_cnt), 128'(vec[k].exp_cnt));
      chk("tbl_released", 128'(fv), 128'(0));
    end

    // Two frames held, then drained back-to-back
    fr = 1'b0;
    for (int j = 0; j < 2 * N_PTS; j++) send(DATA_W'(j + 1), (j % N_PTS) == 0);
    chk("b2b_ready_low", 128'(s_ready), 128'(0));
    for (int j = 0; j < N_PTS; j++) e[j] = DATA_W'(j + 1);
    chk("b2b_first", 128'(xpack()), 128'(e));
    fr = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < N_PTS; j++) e[j] = DATA_W'(j + 9);
    chk("b2b_second_valid", 128'(fv), 128'(1));
    chk("b2b_second", 128'(xpack()), 128'(e));
    chk("b2b_ready_back", 128'(s_ready), 128'(1));
    @(posedge clk); #1;
    chk("b2b_drained", 128'(fv), 128'(0));

    // Mid-frame SOF resync
    do_reset();
    fr = 1'b1;
    send(16'd1, 1'b1); send(16'd2, 1'b0); send(16'd3, 1'b0);
    send(16'd100, 1'b1);
    chk("resync_pulse", 128'(sync_err), 128'(1));
    send(16'd101, 1'b0);
    chk("resync_one_pulse", 128'(sync_err), 128'(0));
    for (int j = 2; j < N_PTS; j++) send(DATA_W'(100 + j), 1'b0);
    @(posedge clk); #1;
    for (int j = 0; j < N_PTS; j++) e[j] = DATA_W'(100 + j);
    chk("resync_frame", 128'(xpack()), 128'(e));
    @(posedge clk); #1;
    chk("resync_cnt", 128'(frame_cnt), 128'(1));

    // Reset with one frame held and a partial frame in flight
    fr = 1'b0;
    for (int j = 0; j < N_PTS; j++) send(DATA_W'(16'h1100 + j), j == 0);
    for (int j = 0; j < 5; j++) send(DATA_W'(16'hEE00 + j), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_valid", 128'(fv), 128'(0));
    chk("mrst_cnt", 128'(frame_cnt), 128'(0));
    chk("mrst_x", 128'(xpack()), 128'(0));
    chk("mrst_ready", 128'(s_ready), 128'(0));
    @(posedge clk); #1;
    chk("mrst_err", 128'(sync_err), 128'(0));
    rst = 1'b0;
    e = {16'hFFFF, 16'h0000, 16'hC000, 16'h4000, 16'hFFFE, 16'h0001, 16'h7FFF, 16'h8000};
    for (int j = 0; j < N_PTS; j++) send(e[j], 1'b0);
    @(posedge clk); #1;
    chk("mrst_frame_valid", 128'(fv), 128'(1));
    chk("mrst_frame", 128'(xpack()), 128'(e));
    fr = 1'b1;
    @(posedge clk); #1;
    chk("mrst_frame_cnt", 128'(frame_cnt), 128'(1));

    // 8th accept on the same edge as the other bank's hand-off
    fr = 1'b0;
    for (int j = 0; j < N_PTS; j++) send(DATA_W'(16'h0A00 + j), j == 0);
    for (int j = 0; j < N_PTS - 1; j++) send(DATA_W'(16'h0B00 + j), j == 0);
    fr = 1'b1;
    send(16'h0B07, 1'b0);
    for (int j = 0; j < N_PTS; j++) e[j] = DATA_W'(16'h0B00 + j);
    chk("coinc_valid", 128'(fv), 128'(1));
    chk("coinc_frame", 128'(xpack()), 128'(e));
    @(posedge clk); #1;
    chk("coinc_drained", 128'(fv), 128'(0));

    // Random traffic, 1000 frames
    target = hand_total + 1000;
    cyc = 0;
    while (hand_total < target && cyc < 60000) begin
      s_valid = ($urandom_range(0, 9) < 7);
      s_data  = DATA_W'($urandom);
      s_sof   = ($urandom_range(0, 31) == 0);
      fr      = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; s_sof = 1'b0; fr = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("rand_frames", 128'(hand_total >= target), 128'(1));
    chk("rand_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
